// File: rtl/ui_pkg.sv
// Shared constants for the UI draw scheduler: state encoding, arrow unit
// indices and default screen geometry.
package ui_pkg;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_START = 3'd2;
    localparam logic [2:0] S_DRAW  = 3'd3;
    localparam logic [2:0] S_HOLD  = 3'd4;

    typedef enum logic [2:0] {
        ST_IDLE  = S_IDLE,
        ST_CLEAR = S_CLEAR,
        ST_START = S_START,
        ST_DRAW  = S_DRAW,
        ST_HOLD  = S_HOLD
    } ui_state_e;

    localparam logic [1:0] UI_UP    = 2'd0;
    localparam logic [1:0] UI_DOWN  = 2'd1;
    localparam logic [1:0] UI_LEFT  = 2'd2;
    localparam logic [1:0] UI_RIGHT = 2'd3;

    localparam int UI_SCREEN_W = 160;
    localparam int UI_SCREEN_H = 120;

endpackage

// File: rtl/ui_clear_scan.sv
// Raster counter for the screen clear: x inner loop, y outer loop, with a
// synchronous restart and a flag marking the final pixel.
module ui_clear_scan #(
    parameter int SCREEN_W = 160,
    parameter int SCREEN_H = 120
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       restart,
    input  logic       en,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic       last
);

    localparam logic [7:0] X_LAST = 8'(SCREEN_W - 1);
    localparam logic [6:0] Y_LAST = 7'(SCREEN_H - 1);

    assign last = (x == X_LAST) && (y == Y_LAST);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x <= '0;
            y <= '0;
        end else if (restart) begin
            x <= '0;
            y <= '0;
        end else if (en) begin
            if (x == X_LAST) begin
                x <= '0;
                y <= (y == Y_LAST) ? '0 : y + 7'd1;
            end else begin
                x <= x + 8'd1;
            end
        end
    end

endmodule

// File: rtl/ui_draw_scheduler.sv
// Shares one VGA adapter write port among four arrow units: clear screen,
// start the selected unit, forward its pixels, then hold the frame.
module ui_draw_scheduler
    import ui_pkg::*;
#(
    parameter int         SCREEN_W     = UI_SCREEN_W,
    parameter int         SCREEN_H     = UI_SCREEN_H,
    parameter logic [2:0] BG_COLOUR    = 3'b000,
    parameter int         HOLD_CYCLES  = 50_000_000,
    parameter int         DRAW_TIMEOUT = 2_000_000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid,
    input  logic [1:0]  cmd_unit,
    input  logic [2:0]  cmd_colour,
    output logic        cmd_ready,
    output logic [3:0]  unit_start,
    input  logic [3:0]  unit_done,
    input  logic [31:0] unit_x,
    input  logic [27:0] unit_y,
    input  logic [3:0]  unit_we,
    output logic [7:0]  vga_x,
    output logic [6:0]  vga_y,
    output logic [2:0]  vga_colour,
    output logic        vga_we,
    output logic        busy,
    output logic        frame_done,
    output logic        timeout_err,
    output logic [2:0]  dbg_state
);

    localparam logic [25:0] HOLD_LAST    = 26'(HOLD_CYCLES - 1);
    localparam logic [25:0] HOLD_PRELAST = 26'(HOLD_CYCLES - 2);
    localparam logic [25:0] DRAW_LAST    = 26'(DRAW_TIMEOUT - 1);

    ui_state_e   state;
    logic [1:0]  sel;
    logic [2:0]  colour;
    logic [25:0] hold_cnt;
    logic [25:0] draw_cnt;
    logic        accept;

    logic [7:0]  clear_x;
    logic [6:0]  clear_y;
    logic        clear_last;

    logic [7:0]  ux [4];
    logic [6:0]  uy [4];

    // Handshake: a command transfers on any rising edge where cmd_valid and
    // cmd_ready are both high; cmd_ready is high only in IDLE, so requests made
    // while busy are simply dropped, never queued.
    assign cmd_ready = (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign dbg_state = state;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            ux[i] = unit_x[8*i +: 8];
            uy[i] = unit_y[7*i +: 7];
        end
    end

    ui_clear_scan #(
        .SCREEN_W (SCREEN_W),
        .SCREEN_H (SCREEN_H)
    ) u_clear_scan (
        .clk     (clk),
        .reset_n (reset_n),
        .restart (accept),
        .en      (state == ST_CLEAR),
        .x       (clear_x),
        .y       (clear_y),
        .last    (clear_last)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= ST_IDLE;
            sel         <= '0;
            colour      <= '0;
            hold_cnt    <= '0;
            draw_cnt    <= '0;
            unit_start  <= '0;
            vga_x       <= '0;
            vga_y       <= '0;
            vga_colour  <= '0;
            vga_we      <= 1'b0;
            frame_done  <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            unit_start <= '0;
            vga_we     <= 1'b0;
            frame_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        sel         <= cmd_unit;
                        colour      <= cmd_colour;
                        timeout_err <= 1'b0;
                        state       <= ST_CLEAR;
                    end
                end
                ST_CLEAR: begin
                    vga_x      <= clear_x;
                    vga_y      <= clear_y;
                    vga_colour <= BG_COLOUR;
                    vga_we     <= 1'b1;
                    if (clear_last) state <= ST_START;
                end
                ST_START: begin
                    unit_start <= 4'b0001 << sel;
                    draw_cnt   <= '0;
                    state      <= ST_DRAW;
                end
                ST_DRAW: begin
                    vga_x      <= ux[sel];
                    vga_y      <= uy[sel];
                    vga_colour <= colour;
                    // Done takes priority over both the pixel write and the timeout.
                    if (unit_done[sel]) begin
                        hold_cnt   <= '0;
                        frame_done <= (HOLD_CYCLES == 1);
                        state      <= ST_HOLD;
                    end else begin
                        vga_we <= unit_we[sel];
                        if (draw_cnt == DRAW_LAST) begin
                            timeout_err <= 1'b1;
                            hold_cnt    <= '0;
                            frame_done  <= (HOLD_CYCLES == 1);
                            state       <= ST_HOLD;
                        end else if (draw_cnt != '1) begin
                            draw_cnt <= draw_cnt + 26'd1;
                        end
                    end
                end
                ST_HOLD: begin
                    // frame_done is raised one edge early so it lands on the last hold cycle.
                    if (hold_cnt == HOLD_LAST) begin
                        state <= ST_IDLE;
                    end else begin
                        frame_done <= (hold_cnt == HOLD_PRELAST);
                        if (hold_cnt != '1) hold_cnt <= hold_cnt + 26'd1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
